// File: rtl/exam_alu_arbiter.sv
// exam_alu_arbiter: round-robin sharing of one start/done compute unit between two requesters, with a timeout watchdog.
// Optional EXAM_ARB_STATS_EN adds saturating grant and timeout counters.
module exam_alu_arbiter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  output logic         ack0,
  output logic [W-1:0] res0,
  output logic         err0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic         ack1,
  output logic [W-1:0] res1,
  output logic         err1,
  output logic         alu_start,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  output logic         busy,
  output logic         last_grant
`ifdef EXAM_ARB_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1,
  output logic [7:0]   timeout_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int WDW = $clog2(TIMEOUT);
  state_t         r_state, w_next;
  logic [WDW-1:0] r_wd;
  logic           r_ptr, r_owner, r_mask0, r_mask1;
  logic           w_el0, w_el1, w_any, w_gnt, w_own, w_ok, w_timeout;
  logic [1:0]     w_op;
  always_comb begin
    w_el0     = req0 && !r_mask0;
    w_el1     = req1 && !r_mask1;
    w_any     = w_el0 || w_el1;
    w_gnt     = (w_el0 && w_el1) ? r_ptr : w_el1;
    w_op      = w_gnt ? op1 : op0;
    w_own     = (r_state == IDLE) ? w_gnt : r_owner;
    w_ok      = (r_state == WAIT) && alu_done;
    w_timeout = r_wd == WDW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = (w_op == 2'd3) ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (alu_done || w_timeout) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd       <= '0;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_mask0    <= 1'b0;
      r_mask1    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      res0       <= '0;
      res1       <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      busy       <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      alu_start <= w_next == ISSUE;
      busy      <= w_next != IDLE;
      ack0      <= (w_next == RESP) && !w_own;
      ack1      <= (w_next == RESP) && w_own;
      r_wd      <= (r_state == WAIT) ? r_wd + 1'b1 : '0;
      r_mask0   <= (r_state == RESP) && !r_owner;
      r_mask1   <= (r_state == RESP) && r_owner;
      if (r_state == RESP) r_ptr <= !r_owner;
      if (r_state == IDLE && w_any) begin
        r_owner    <= w_gnt;
        last_grant <= w_gnt;
        alu_op     <= w_op;
        alu_x      <= w_gnt ? x1 : x0;
        alu_y      <= w_gnt ? y1 : y0;
      end
      if (w_next == RESP && w_own) begin
        res1 <= w_ok ? alu_result : '0;
        err1 <= !w_ok;
      end
      if (w_next == RESP && !w_own) begin
        res0 <= w_ok ? alu_result : '0;
        err0 <= !w_ok;
      end
    end
  end
`ifdef EXAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (r_state == RESP && !r_owner && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (r_state == RESP && r_owner && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (r_state == WAIT && !alu_done && w_timeout && !(&timeout_cnt)) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_exam_alu_arbiter.sv
// tb_exam_alu_arbiter: directed bench for exam_alu_arbiter with a latency-programmable model of the shared unit.
module tb_exam_alu_arbiter;
  logic        clk, rst;
  logic        req0, req1, ack0, ack1, err0, err1;
  logic [1:0]  op0, op1, alu_op;
  logic [15:0] x0, y0, x1, y1, res0, res1, alu_x, alu_y, alu_result;
  logic        alu_start, alu_done, busy, last_grant;
  logic        m_done, inj_done;
  int          unit_lat, cnt;
  logic [15:0] unit_res;
  int          checks, failures;
`ifdef EXAM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  logic [7:0]  timeout_cnt;
`endif

  exam_alu_arbiter #(.W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .x0(x0), .y0(y0), .ack0(ack0), .res0(res0), .err0(err0),
    .req1(req1), .op1(op1), .x1(x1), .y1(y1), .ack1(ack1), .res1(res1), .err1(err1),
    .alu_start(alu_start), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy), .last_grant(last_grant)
`ifdef EXAM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .timeout_cnt(timeout_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_done   = m_done | inj_done;
  assign alu_result = alu_done ? unit_res : 16'hDEAD;

  // unit model: done is seen unit_lat cycles after the start cycle; 0 means it never answers
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) cnt <= 0;
    else if (alu_start && unit_lat != 0) begin
      cnt    <= unit_lat - 1;
      m_done <= unit_lat == 1;
    end else if (cnt != 0) begin
      cnt    <= cnt - 1;
      m_done <= cnt == 1;
    end
  end

  task automatic do_op(input logic who, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input int lat, output int ack_i, output int starts);
    unit_lat = lat;
    ack_i    = -1;
    starts   = 0;
    if (who) begin req1 = 1'b1; op1 = op; x1 = x; y1 = y; end
    else     begin req0 = 1'b1; op0 = op; x0 = x; y0 = y; end
    for (int i = 1; i <= 60 && ack_i < 0; i++) begin
      @(negedge clk);
      if (alu_start) starts++;
      if (who ? ack1 : ack0) ack_i = i;
    end
    if (who) req1 = 1'b0;
    else     req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; op0 = 2'd1; op1 = 2'd2;
    x0 = 16'h55; y0 = 16'h66; x1 = 16'h77; y1 = 16'h88;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, alu_start, busy, last_grant} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {ack0, ack1, err0, err1, alu_start, busy, last_grant});
    end
    checks++;
    if ({res0, res1} !== 32'h0) begin
      failures++; $display("FAIL reset_res got=%h exp=0", {res0, res1});
    end
    checks++;
    if ({alu_op, alu_x, alu_y} !== 34'h0) begin
      failures++; $display("FAIL reset_alu got=%h exp=0", {alu_op, alu_x, alu_y});
    end
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    logic [15:0] r1;
    int a, starts, acks, acks1;
    r1 = res1; a = -1; starts = 0; acks = 0; acks1 = 0;
    unit_lat = 5; unit_res = 16'd81;
    req0 = 1'b1; op0 = 2'd0; x0 = 16'd3; y0 = 16'd4;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin x0 = 16'h99; y0 = 16'h77; op0 = 2'd2; end
      if (alu_start) starts++;
      if (ack1) acks1++;
      if (ack0) begin
        acks++;
        if (a < 0) a = i;
        req0 = 1'b0;
      end
    end
    checks++; if (starts !== 1) begin failures++; $display("FAIL single_starts got=%0d exp=1", starts); end
    checks++; if (acks !== 1) begin failures++; $display("FAIL single_ack0 got=%0d exp=1", acks); end
    checks++; if (acks1 !== 0) begin failures++; $display("FAIL single_ack1 got=%0d exp=0", acks1); end
    checks++; if (a !== 7) begin failures++; $display("FAIL single_latency got=%0d exp=7", a); end
    checks++; if (res0 !== 16'd81 || err0 !== 1'b0) begin failures++; $display("FAIL single_res0 got=%0d/%b exp=81/0", res0, err0); end
    checks++; if (res1 !== r1) begin failures++; $display("FAIL single_res1 got=%h exp=%h", res1, r1); end
    checks++; if (last_grant !== 1'b0) begin failures++; $display("FAIL single_last_grant got=%b exp=0", last_grant); end
    checks++;
    if (alu_op !== 2'd0 || alu_x !== 16'd3 || alu_y !== 16'd4) begin
      failures++; $display("FAIL single_latch got=%0d/%h/%h exp=0/3/4", alu_op, alu_x, alu_y);
    end
  endtask

  task automatic test_op3();
    logic [15:0] r0;
    int a, s;
    r0 = res0;
    do_op(1'b1, 2'd3, 16'hFFFF, 16'h0, 5, a, s);
    checks++; if (a !== 1) begin failures++; $display("FAIL op3_latency got=%0d exp=1", a); end
    checks++; if (s !== 0) begin failures++; $display("FAIL op3_starts got=%0d exp=0", s); end
    checks++; if (err1 !== 1'b1 || res1 !== 16'h0) begin failures++; $display("FAIL op3_res1 got=%h/%b exp=0/1", res1, err1); end
    checks++; if (res0 !== r0) begin failures++; $display("FAIL op3_res0 got=%h exp=%h", res0, r0); end
    checks++;
    if (last_grant !== 1'b1 || alu_op !== 2'd3 || alu_x !== 16'hFFFF) begin
      failures++; $display("FAIL op3_latch got=%b/%0d/%h exp=1/3/ffff", last_grant, alu_op, alu_x);
    end
  endtask

  task automatic test_round_robin();
    int seq[4];
    int n;
    int exp_seq[4] = '{0, 1, 0, 1};
    n = 0;
    for (int k = 0; k < 4; k++) seq[k] = -1;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    unit_lat = 2; unit_res = 16'h1234;
    op0 = 2'd1; op1 = 2'd1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 && n < 4) begin seq[n] = 0; n++; req0 = 1'b0; end else req0 = 1'b1;
      if (ack1 && n < 4) begin seq[n] = 1; n++; req1 = 1'b0; end else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (n !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seq[k] !== exp_seq[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
    end
    checks++; if (res0 !== 16'h1234 || res1 !== 16'h1234) begin failures++; $display("FAIL rr_res got=%h/%h exp=1234/1234", res0, res1); end
  endtask

  task automatic test_mask();
    int a1, a2, s2, st;
    a1 = -1; a2 = -1; s2 = -1; st = 0;
    unit_lat = 1; req0 = 1'b1; op0 = 2'd2;
    for (int i = 1; i <= 40 && a2 < 0; i++) begin
      @(negedge clk);
      if (alu_start) begin st++; if (st == 2) s2 = i; end
      if (ack0) begin if (a1 < 0) a1 = i; else a2 = i; end
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a1 !== 3) begin failures++; $display("FAIL mask_min_latency got=%0d exp=3", a1); end
    checks++; if (a2 < 0) begin failures++; $display("FAIL mask_second_ack got=%0d exp=>0", a2); end
    checks++; if (s2 - a1 !== 3) begin failures++; $display("FAIL mask_regrant_gap got=%0d exp=3", s2 - a1); end
  endtask

  task automatic test_timeout();
    int a, s, acks, bsy;
    acks = 0; bsy = 0;
    do_op(1'b0, 2'd2, 16'h5, 16'h0, 0, a, s);
    checks++; if (a !== 10) begin failures++; $display("FAIL timeout_latency got=%0d exp=10", a); end
    checks++; if (s !== 1) begin failures++; $display("FAIL timeout_starts got=%0d exp=1", s); end
    checks++; if (err0 !== 1'b1 || res0 !== 16'h0) begin failures++; $display("FAIL timeout_res0 got=%h/%b exp=0/1", res0, err0); end
    unit_res = 16'h4321;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
      if (busy) bsy++;
    end
    checks++; if (acks !== 0 || bsy !== 0) begin failures++; $display("FAIL stray_done got=%0d acks %0d busy exp=0/0", acks, bsy); end
    checks++; if (err0 !== 1'b1 || res0 !== 16'h0) begin failures++; $display("FAIL stray_done_res0 got=%h/%b exp=0/1", res0, err0); end
  endtask

  task automatic test_reset_wait();
    logic seen, d0, d1;
    seen = 1'b0; d0 = 1'b0; d1 = 1'b0;
    unit_lat = 0; req0 = 1'b1; op0 = 2'd0; x0 = 16'hA5;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (alu_start) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstwait_start got=0 exp=1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, alu_start, busy, last_grant} !== 7'b0) begin
      failures++; $display("FAIL rstwait_flags got=%b exp=0", {ack0, ack1, err0, err1, alu_start, busy, last_grant});
    end
    checks++;
    if ({res0, res1, alu_op, alu_x, alu_y} !== 66'h0) begin
      failures++; $display("FAIL rstwait_data got=%h exp=0", {res0, res1, alu_op, alu_x, alu_y});
    end
    req1 = 1'b1; rst = 1'b0; unit_lat = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || last_grant !== 1'b0) begin failures++; $display("FAIL rstwait_pointer got=%b/%b exp=1/0", busy, last_grant); end
    for (int i = 0; i < 40 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (ack0) begin d0 = 1'b1; req0 = 1'b0; end
      if (ack1) begin d1 = 1'b1; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (!(d0 && d1)) begin failures++; $display("FAIL rstwait_drain got=%b%b exp=11", d0, d1); end
  endtask

`ifdef EXAM_ARB_STATS_EN
  task automatic test_stats();
    int a, s;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    repeat (3) do_op(1'b0, 2'd1, 16'h3, 16'h1, 1, a, s);
    do_op(1'b1, 2'd0, 16'h2, 16'h2, 0, a, s);
    checks++; if (grant_cnt0 !== 16'd3) begin failures++; $display("FAIL stats_grant0 got=%0d exp=3", grant_cnt0); end
    checks++; if (grant_cnt1 !== 16'd1) begin failures++; $display("FAIL stats_grant1 got=%0d exp=1", grant_cnt1); end
    checks++; if (timeout_cnt !== 8'd1) begin failures++; $display("FAIL stats_timeout got=%0d exp=1", timeout_cnt); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0; inj_done = 1'b0; unit_lat = 0; unit_res = 16'h0;
    test_reset();
    test_single();
    test_op3();
    test_round_robin();
    test_mask();
    test_timeout();
    test_reset_wait();
`ifdef EXAM_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/exam_alu_arbiter.md
Name: exam_alu_arbiter

Overview:
- Shares one iterative multi-cycle compute unit between two requesters. The compute unit performs exponent, pop-count and parity, and uses a start/done handshake.
- Sits between the top-level wrapper's requesters and the shared unit.
- Arbitrates round-robin, issues a one-cycle start, watches done with a timeout watchdog, and returns result/ack/err to the owning requester.

Parameters:
- W, 16, operand/result width
- TIMEOUT, 1024, max cycles in WAIT before the operation is aborted (must be >= 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req0  in  1  requester 0 request; held high until ack0
- op0  in  2  requester 0 opcode: 0 EXP (x^y), 1 POPCOUNT(x+y), 2 ODD_PARITY(x), 3 reserved
- x0, y0  in  W each  requester 0 operands
- ack0  out  1  one-cycle completion pulse to requester 0
- res0  out  W  requester 0 result; valid with ack0, held afterwards
- err0  out  1  requester 0 error flag; valid with ack0, held afterwards
- req1, op1, x1, y1, ack1, res1, err1: same as requester 0, for requester 1
- alu_start  out  1  one-cycle start to the shared unit
- alu_op  out  2  latched opcode
- alu_x, alu_y  out  W each  latched operands
- alu_done  in  1  shared unit completion
- alu_result  in  W  shared unit result, valid with alu_done
- busy  out  1  high in every state except IDLE
- last_grant  out  1  index of the most recently granted requester

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0. State = IDLE, priority pointer = 0, watchdog = 0, mask = none.
- Reset mid-operation aborts the operation and produces no ack. The shared unit shares the same rst.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - Eligible requests are req0/req1 with the mask applied.
  - If both are eligible, grant the requester selected by the pointer. If one is eligible, grant it.
  - Latch owner, op, x, y into alu_op/alu_x/alu_y and set last_grant = owner.
  - op==3: skip the unit. Go to RESP with error=1, result=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - alu_start=1 for exactly this one cycle. Watchdog cleared.
  - Go to WAIT.
  - alu_done is ignored in ISSUE.
- WAIT:
  - alu_start=0. Watchdog increments each cycle.
  - If alu_done: capture alu_result, error=0, go to RESP.
  - Else if watchdog == TIMEOUT-1: result=0, error=1, go to RESP.
  - alu_done on the timeout cycle counts as success.
- RESP:
  - ack_owner=1 for one cycle. res_owner and err_owner are updated on this cycle's edge and hold until that owner's next RESP.
  - The other requester's res/err are untouched.
  - Pointer = ~owner. Mask the owner's req for the first IDLE cycle only.
  - Go to IDLE.
- alu_done outside WAIT is ignored.

Timing and handshake rules:
- Minimum latency: req sampled at edge k → ISSUE at k+1 → alu_done seen at k+2 → ack at k+3.
- Requester changes of op/x/y after the grant edge have no effect.
- req dropping before ack does not cancel the operation; ack still pulses.

Optional Feature:
- Macro: EXAM_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt0 (16), grant_cnt1 (16) and timeout_cnt (8).
  - grant_cnt0/grant_cnt1 increment on each RESP for that owner, including op==3 and timeouts.
  - timeout_cnt increments on each watchdog abort.
  - All three counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Single requester, op=0, x=3, y=4; unit returns done 5 cycles after start with 81 → alu_start high exactly 1 cycle; ack0 pulses once; res0=81, err0=0; res1 unchanged; last_grant=0.
- req0 and req1 both high from reset, each held until its ack, with done 2 cycles after each start → grant order 0,1,0,1; no requester is served twice in a row; the one-cycle mask prevents re-grant of the owner.
- op1=3, x1=0xFFFF → ack1 at IDLE+1; err1=1, res1=0; alu_start never asserted.
- TIMEOUT=8, unit never responds → ack0 exactly 8 cycles after the ISSUE cycle ends, err0=1, res0=0. A later alu_done pulse in IDLE is ignored with no ack.
- rst asserted during WAIT → next edge: all outputs 0, busy=0, no ack. After rst deasserts, with req1 high, requester 1 is granted first only if req0 is low (pointer = 0).
- With EXAM_ARB_STATS_EN: 3 grants to requester 0, 1 timeout on requester 1 → grant_cnt0=3, grant_cnt1=1, timeout_cnt=1.
